// File: rtl/hazard_branch_ctrl.sv
// Pipeline control sequencer for the 5-stage MIPS datapath.
// Resolves taken branches at MEM, stalls on load-use hazards, flushes
// younger instructions, and keeps saturating event counters for debug.
module hazard_branch_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int FLUSH_HOLD = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Branch_MEM,
    input  logic             Zero_MEM,
    input  logic             MemRead_EX,
    input  logic [4:0]       Rt_EX,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             UsesRt_ID,
    output logic             PCSrc,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [1:0]       State
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Hold values: number of cycles still to spend in STALL/FLUSH after entry
    localparam logic [3:0] FLUSH_HOLD_V = 4'(FLUSH_HOLD);
    localparam logic [3:0] STALL_HOLD_V = 4'(LOAD_STALL - 1);
    localparam bit         FLUSH_EXTEND = (FLUSH_HOLD > 0);
    localparam bit         STALL_EXTEND = (LOAD_STALL > 1);

    state_t     state_reg;
    logic [3:0] hold_reg;
    logic       taken;
    logic       hazard;
    logic       flush_act;
    logic       stall_act;

    assign taken  = Branch_MEM & Zero_MEM;
    assign hazard = MemRead_EX & (Rt_EX != 5'd0) &
                    ((Rt_EX == Rs_ID) | (UsesRt_ID & (Rt_EX == Rt_ID)));

    // Action decode: the branch is older than the load, so flush wins over any stall
    always_comb begin
        flush_act = taken | (state_reg == FLUSH);
        stall_act = 1'b0;
        if (!flush_act) begin
            stall_act = (state_reg == STALL) | ((state_reg == RUN) & hazard);
        end
    end

    assign PCSrc      = taken;
    assign PCWrite    = ~stall_act;
    assign IFIDWrite  = ~stall_act;
    assign IFIDFlush  = flush_act;
    assign IDEXFlush  = flush_act | stall_act;
    assign EXMEMFlush = flush_act;
    assign State      = state_reg;

    // Sequencer: tracks multi-cycle stall/flush windows with a down-counting hold
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= RUN;
            hold_reg  <= 4'd0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (taken) begin
                        if (FLUSH_EXTEND) begin
                            state_reg <= FLUSH;
                            hold_reg  <= FLUSH_HOLD_V;
                        end
                    end else if (hazard) begin
                        if (STALL_EXTEND) begin
                            state_reg <= STALL;
                            hold_reg  <= STALL_HOLD_V;
                        end
                    end
                end
                STALL, FLUSH: begin
                    if (taken) begin
                        if (FLUSH_EXTEND) begin
                            state_reg <= FLUSH;
                            hold_reg  <= FLUSH_HOLD_V;
                        end else begin
                            state_reg <= RUN;
                            hold_reg  <= 4'd0;
                        end
                    end else if (hold_reg <= 4'd1) begin
                        state_reg <= RUN;
                        hold_reg  <= 4'd0;
                    end else begin
                        hold_reg <= hold_reg - 4'd1;
                    end
                end
                default: begin
                    // Unused encoding: fall back to normal running
                    state_reg <= RUN;
                    hold_reg  <= 4'd0;
                end
            endcase
        end
    end

    // Saturating statistics: one count per stall cycle, one per taken branch
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_act && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + 1'b1;
            end
            if (taken && (FlushCount != {CNT_W{1'b1}})) begin
                FlushCount <= FlushCount + 1'b1;
            end
        end
    end

endmodule
